// File: rtl/gates_sweep_checker.sv
// Sweeps all {a,b} combinations through an external two-input gate block for
// NUM_PASSES passes, compares the seven responses and reports a verdict.
module gates_sweep_checker #(
    parameter int NUM_PASSES = 2,
    parameter int SETTLE     = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic       c1,
    input  logic       c2,
    input  logic       c3,
    input  logic       c4,
    input  logic       c5,
    input  logic       c6,
    input  logic       c7,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic [1:0] fail_ab,
    output logic [6:0] fail_mask
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);
    localparam logic [7:0] LAST_PASS = 8'(NUM_PASSES - 1);

    state_e     state_q;
    logic [1:0] ab_q;
    logic [3:0] settle_q;
    logic [7:0] pass_cnt_q;
    logic       busy_q, done_q, pass_q;
    logic [7:0] err_q;
    logic [1:0] fail_ab_q;
    logic [6:0] fail_mask_q;

    logic [6:0] exp_d, mismatch_d;
    logic       sample_d, fail_d, last_d;
    logic [7:0] err_d;

    // Expected responses come from the registered stimulus actually driven out.
    always_comb begin
        exp_d      = {~ab_q[1], ~(ab_q[1] ^ ab_q[0]), ab_q[1] ^ ab_q[0],
                      ~(ab_q[1] | ab_q[0]), ~(ab_q[1] & ab_q[0]),
                      ab_q[1] | ab_q[0], ab_q[1] & ab_q[0]};
        mismatch_d = {c7, c6, c5, c4, c3, c2, c1} ^ exp_d;
        sample_d   = (state_q == RUN) && (settle_q == SETTLE_M1);
        fail_d     = sample_d && (mismatch_d != 7'd0);
        err_d      = (fail_d && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
        last_d     = (ab_q == 2'b11) && (pass_cnt_q == LAST_PASS);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ab_q        <= 2'b00;
            settle_q    <= 4'd0;
            pass_cnt_q  <= 8'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_q       <= 8'd0;
            fail_ab_q   <= 2'b00;
            fail_mask_q <= 7'd0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q     <= RUN;
                        ab_q        <= 2'b00;
                        settle_q    <= 4'd0;
                        pass_cnt_q  <= 8'd0;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        pass_q      <= 1'b0;
                        err_q       <= 8'd0;
                        fail_ab_q   <= 2'b00;
                        fail_mask_q <= 7'd0;
                    end
                end
                RUN: begin
                    settle_q <= sample_d ? 4'd0 : settle_q + 4'd1;
                    if (sample_d) begin
                        err_q <= err_d;
                        // err_q is still zero only until the first failure lands.
                        if (fail_d && err_q == 8'd0) begin
                            fail_ab_q   <= ab_q;
                            fail_mask_q <= mismatch_d;
                        end
                        if (last_d) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_d == 8'd0);
                            ab_q    <= 2'b00;
                        end else begin
                            ab_q <= ab_q + 2'd1;
                            if (ab_q == 2'b11) pass_cnt_q <= pass_cnt_q + 8'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign a         = ab_q[1];
    assign b         = ab_q[0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_ab   = fail_ab_q;
    assign fail_mask = fail_mask_q;

endmodule

// File: tb/tb_gates_sweep_checker.sv
// Directed bench: three checker instances, each with its own fault-injectable gate model.
module tb_gates_sweep_checker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Gate model, bit i-1 = c_i.
    function automatic logic [6:0] gates(input logic ga, input logic gb);
        return {~ga, ~(ga ^ gb), ga ^ gb, ~(ga | gb), ~(ga & gb), ga | gb, ga & gb};
    endfunction

    logic       st0 = 0, st1 = 0, st2 = 0;
    logic [6:0] inv0 = 0, f0_0 = 0, f1_0 = 0, inv2 = 0;

    logic       a0, b0, busy0, done0, pass0;
    logic [7:0] err0;
    logic [1:0] fab0;
    logic [6:0] fm0, c0;
    logic       a1, b1, busy1, done1, pass1;
    logic [7:0] err1;
    logic [1:0] fab1;
    logic [6:0] fm1, c1v;
    logic       a2, b2, busy2, done2, pass2;
    logic [7:0] err2;
    logic [1:0] fab2;
    logic [6:0] fm2, c2v;

    assign c0  = ((gates(a0, b0) ^ inv0) & ~f0_0) | f1_0;
    assign c1v = gates(a1, b1);
    assign c2v = gates(a2, b2) ^ inv2;

    gates_sweep_checker #(.NUM_PASSES(2), .SETTLE(1)) u0 (
        .clk(clk), .rst_n(rst_n), .start(st0), .a(a0), .b(b0),
        .c1(c0[0]), .c2(c0[1]), .c3(c0[2]), .c4(c0[3]), .c5(c0[4]), .c6(c0[5]), .c7(c0[6]),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .fail_ab(fab0), .fail_mask(fm0));

    gates_sweep_checker #(.NUM_PASSES(1), .SETTLE(3)) u1 (
        .clk(clk), .rst_n(rst_n), .start(st1), .a(a1), .b(b1),
        .c1(c1v[0]), .c2(c1v[1]), .c3(c1v[2]), .c4(c1v[3]), .c5(c1v[4]), .c6(c1v[5]), .c7(c1v[6]),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .fail_ab(fab1), .fail_mask(fm1));

    gates_sweep_checker #(.NUM_PASSES(100), .SETTLE(1)) u2 (
        .clk(clk), .rst_n(rst_n), .start(st2), .a(a2), .b(b2),
        .c1(c2v[0]), .c2(c2v[1]), .c3(c2v[2]), .c4(c2v[3]), .c5(c2v[4]), .c6(c2v[5]), .c7(c2v[6]),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .fail_ab(fab2), .fail_mask(fm2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_u0", {a0, b0, busy0, done0, pass0, err0, fab0, fm0}, 0);
        chk("rst_u2", {a2, b2, busy2, done2, pass2, err2, fab2, fm2}, 0);
        rst_n = 1'b1;
        tick();

        // Clean run, NUM_PASSES=2, SETTLE=1
        st0 = 1; tick(); st0 = 0;                       // E0
        chk("t1_e0", {a0, b0, busy0, done0}, 4'b0010);
        for (int k = 1; k < 8; k++) begin
            tick();
            chk("t1_ab", {a0, b0}, k % 4);
        end
        chk("t1_busy_e7", {busy0, done0}, 2'b10);
        tick();                                         // E0+8
        chk("t1_done", {busy0, done0, pass0}, 3'b011);
        chk("t1_err", {err0, fab0, fm0}, 0);
        chk("t1_ab_end", {a0, b0}, 0);

        // Back-to-back start with c5 stuck at 0
        f0_0 = 7'b0010000;
        st0 = 1; tick(); st0 = 0;
        chk("t2_done_drop", {busy0, done0, pass0}, 3'b100);
        repeat (7) tick();                              // E0+7
        st0 = 1; tick(); st0 = 0;                       // E0+8, start ignored
        chk("t2_done", {busy0, done0, pass0}, 3'b010);
        chk("t2_err", err0, 4);
        chk("t2_fab", fab0, 2'b01);
        chk("t2_fm", fm0, 7'b0010000);
        tick();
        chk("t2_start_ign", {busy0, done0, err0}, {2'b01, 8'd4});
        f0_0 = 0;

        // SETTLE=3, NUM_PASSES=1, stray start at E0+5
        st1 = 1; tick(); st1 = 0;                       // E0
        chk("t3_e0", {a1, b1, busy1}, 3'b001);
        for (int t = 1; t < 12; t++) begin
            if (t == 5) st1 = 1;
            tick();
            st1 = 0;
            chk("t3_ab", {a1, b1, done1}, {2'(t / 3), 1'b0});
        end
        tick();                                         // E0+12
        chk("t3_done", {busy1, done1, pass1, err1}, {3'b011, 8'd0});

        // Reset mid-run with c1 stuck at 1
        f1_0 = 7'b0000001;
        st0 = 1; tick(); st0 = 0;
        repeat (3) tick();                              // E0+3
        chk("t4_pre_err", err0, 3);
        #2 rst_n = 0;
        #1;
        chk("t4_async", {a0, b0, busy0, done0, pass0, err0, fab0, fm0}, 0);
        chk("t4_u1_clr", {done1, pass1}, 0);
        tick();
        chk("t4_idle", {busy0, done0}, 0);
        rst_n = 1; f1_0 = 0;
        tick();
        st0 = 1; tick(); st0 = 0;
        repeat (8) tick();
        chk("t4_clean", {busy0, done0, pass0, err0, fm0}, {3'b011, 8'd0, 7'd0});

        // Every response inverted, NUM_PASSES=100
        inv2 = 7'h7F;
        st2 = 1; tick(); st2 = 0;
        repeat (254) tick();                            // E0+254
        chk("t5_err254", err2, 254);
        tick();
        chk("t5_err255", err2, 255);
        repeat (144) tick();                            // E0+399
        chk("t5_notdone", {busy2, done2}, 2'b10);
        tick();                                         // E0+400
        chk("t5_done", {busy2, done2, pass2}, 3'b010);
        chk("t5_sat", err2, 255);
        chk("t5_first", {fab2, fm2}, {2'b00, 7'h7F});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
